// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, serial FSM states and a bit-level XNOR helper.
package alu_pkg;
    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;

    function automatic logic xnor_bit(input logic a, input logic b);
        return ~(a ^ b);
    endfunction
endpackage

// File: rtl/xnor8_serial_if.sv
// Operand/result handshake bundle for the bit-serial XNOR unit.
interface xnor8_serial_if #(parameter int WIDTH = alu_pkg::ALU_WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             eq;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, eq
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, eq
    );
endinterface

// File: rtl/serial_shifter.sv
// Load/shift-right register; exposes only the LSB since the serial datapath consumes one bit per cycle.
module serial_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_lsb
);
    logic [WIDTH-1:0] r_q;

    // Load has priority so a new operand can never be mixed with a stale shift.
    always_ff @(posedge clk) begin
        if (rst)          r_q <= '0;
        else if (i_load)  r_q <= i_d;
        else if (i_shift) r_q <= {1'b0, r_q[WIDTH-1:1]};
    end

    assign o_lsb = r_q[0];
endmodule

// File: rtl/xnor8_serial.sv
// Bit-serial XNOR/equality unit: one bit pair per clock, LSB first, result rebuilt MSB-inward.
module xnor8_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    xnor8_serial_if.slave  bus
);
    localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    ser_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_in_ready;
    logic             r_out_valid;

    logic w_accept;
    logic w_shift;
    logic w_a_lsb;
    logic w_b_lsb;

    assign w_accept = r_in_ready && bus.in_valid;
    assign w_shift  = (r_state == SHIFT);

    serial_shifter #(.WIDTH(WIDTH)) u_sh_a (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_d     (bus.a),
        .o_lsb   (w_a_lsb)
    );

    serial_shifter #(.WIDTH(WIDTH)) u_sh_b (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_d     (bus.b),
        .o_lsb   (w_b_lsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_result   <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // New bit enters at the MSB; after WIDTH shifts bit 0 lands at result[0].
                    r_result <= {xnor_bit(w_a_lsb, w_b_lsb), r_result[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.eq        = &r_result;
endmodule

// File: tb/tb_xnor8_serial.sv
// Randomized and directed bench for xnor8_serial against a word-level XNOR/equality model.
module tb_xnor8_serial;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    xnor8_serial_if #(.WIDTH(8)) bus ();

    xnor8_serial #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    // One full transaction; junk keeps in_valid high with scrambled operands after the accept.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int stall, input bit junk);
        logic [7:0] exp_res;
        logic       exp_eq;
        int         n;
        exp_res = ~(a ^ b);
        exp_eq  = (a == b);
        n = 0;
        while (!bus.in_ready && n < 50) begin tick(); n++; end
        chk("ready_wait", 32'(bus.in_ready), 32'd1);
        bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        tick();
        chk("busy_after_accept", 32'(bus.in_ready), 32'd0);
        bus.in_valid = junk;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            if (junk) begin bus.a = 8'($urandom); bus.b = 8'($urandom); end
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd8);
        chk("result", 32'(bus.result), 32'(exp_res));
        chk("eq", 32'(bus.eq), 32'(exp_eq));
        chk("ready_in_done", 32'(bus.in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_result", 32'(bus.result), 32'(exp_res));
            chk("stall_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
        chk("post_hs_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int         seen;
        int         t_seen[2];
        logic [7:0] r_seen[2];
        logic       e_seen[2];
        n_chk = 0;
        n_pass = 0;

        // Reset with in_valid asserted must not accept.
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_eq", 32'(bus.eq), 32'd0);
        rst = 1'b0; bus.in_valid = 1'b0;
        tick();
        chk("no_accept_in_rst", 32'(bus.in_ready), 32'd1);

        do_op(8'hA5, 8'hA5, 0, 1'b0);
        do_op(8'hF0, 8'h0F, 0, 1'b0);
        do_op(8'h3C, 8'h35, 5, 1'b0);
        do_op(8'h6E, 8'h19, 2, 1'b1);

        // Abort in the 4th shift cycle; nothing may ever be emitted.
        bus.a = 8'h81; bus.b = 8'h80; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_eq", 32'(bus.eq), 32'd0);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin tick(); if (bus.out_valid) seen++; end
        chk("abort_no_emit", 32'(seen), 32'd0);

        // Back-to-back with both handshakes tied high.
        bus.a = 8'h00; bus.b = 8'h00; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.a = 8'h55; bus.b = 8'hAA;
        seen = 0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (bus.out_valid && seen < 2) begin
                t_seen[seen] = i; r_seen[seen] = bus.result; e_seen[seen] = bus.eq;
                seen++;
            end
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        chk("b2b_count", 32'(seen), 32'd2);
        if (seen == 2) begin
            chk("b2b_t0", 32'(t_seen[0]), 32'd8);
            chk("b2b_r0", 32'(r_seen[0]), 32'hFF);
            chk("b2b_e0", 32'(e_seen[0]), 32'd1);
            chk("b2b_spacing", 32'(t_seen[1] - t_seen[0]), 32'd10);
            chk("b2b_r1", 32'(r_seen[1]), 32'h00);
            chk("b2b_e1", 32'(e_seen[1]), 32'd0);
        end

        for (int k = 0; k < 20; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            do_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
